// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the handshaked data memory (dmem_hs) and its
// lane formatting helper (dmem_lane_fmt).
//   size_e   : access size encoding as it appears on req_size
//   state_e  : FSM states of the request/response sequencer
//   req_t    : one captured load/store request
//   WAIT_MAX : largest supported number of wait states
//   normSize : folds the reserved size code 3 onto a word access
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Size stays a raw 2-bit field so the reserved code survives capture.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        isUnsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam int WAIT_MAX = 15;

  // The reserved size code behaves exactly like a word access.
  function automatic size_e normSize(input logic [1:0] size);
    return (size == 2'd3) ? SZ_WORD : size_e'(size);
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// -----------------------------------------------------------------------------
// dmem_lane_fmt
// Combinational byte-lane formatter for a 32-bit little-endian memory word.
// Produces the store byte enables and merged word, the right-justified and
// extended load value, and a misalignment flag. Also used by the cache fill
// path, so it carries no state.
// Ports:
//   size_i       in  2   access size (0 byte, 1 half, 2/3 word)
//   unsigned_i   in  1   zero-extend (1) or sign-extend (0) sub-word loads
//   offset_i     in  2   byte offset within the word (addr[1:0])
//   wdata_i      in  32  right-justified store data
//   word_i       in  32  current memory word
//   be_o         out 4   lanes written by a store
//   merged_o     out 32  word after the store merge
//   rdata_o      out 32  extended load result
//   misaligned_o out 1   half at odd offset, or word at non-zero offset
// Sub-word accesses with stray low offset bits are forced onto the naturally
// aligned lane here; the caller decides whether misalignment is an error.
// -----------------------------------------------------------------------------
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [3:0]  be_o,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  size_e       sz;
  logic [1:0]  off;
  logic [31:0] wideData;
  logic [7:0]  selByte;
  logic [15:0] selHalf;

  // Decode size into an aligned offset, lane enables and replicated store
  // data, so every enabled lane already sees the right source byte.
  always_comb begin
    sz           = normSize(size_i);
    off          = 2'b00;
    misaligned_o = 1'b0;
    be_o         = 4'b1111;
    wideData     = wdata_i;
    case (sz)
      SZ_BYTE: begin
        off      = offset_i;
        be_o     = 4'b0001 << offset_i;
        wideData = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        off          = {offset_i[1], 1'b0};
        misaligned_o = offset_i[0];
        be_o         = offset_i[1] ? 4'b1100 : 4'b0011;
        wideData     = {2{wdata_i[15:0]}};
      end
      default: begin
        misaligned_o = (offset_i != 2'b00);
      end
    endcase
  end

  // Store merge: enabled lanes take new data, the rest keep the old word.
  always_comb begin
    merged_o = word_i;
    for (int i = 0; i < 4; i++) begin
      if (be_o[i]) begin
        merged_o[8*i +: 8] = wideData[8*i +: 8];
      end
    end
  end

  // Load path: pick the addressed lanes, then extend to 32 bits.
  always_comb begin
    selByte = word_i[8*off +: 8];
    selHalf = off[1] ? word_i[31:16] : word_i[15:0];
    rdata_o = word_i;
    case (sz)
      SZ_BYTE: rdata_o = unsigned_i ? {24'h0, selByte} : {{24{selByte[7]}}, selByte};
      SZ_HALF: rdata_o = unsigned_i ? {16'h0, selHalf} : {{16{selHalf[15]}}, selHalf};
      default: rdata_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_hs.sv
// -----------------------------------------------------------------------------
// dmem_hs
// Handshaked data memory for the multi-cycle and pipelined MIPS cores. Takes
// one load/store at a time over valid/ready, waits WAIT_CYCLES cycles, then
// performs the access and returns a one-cycle response pulse.
// Parameters:
//   DEPTH        number of 32-bit words (power of two, 4..4096)
//   WAIT_CYCLES  wait states between acceptance and access (0..WAIT_MAX)
// Ports:
//   clk           in  1   clock, all state on posedge
//   reset         in  1   synchronous active-high reset
//   req_valid     in  1   request present
//   req_ready     out 1   high only while idle
//   req_we        in  1   1 store, 0 load
//   req_size      in  2   0 byte, 1 half, 2 word, 3 treated as word
//   req_unsigned  in  1   loads: 1 zero-extend, 0 sign-extend
//   req_addr      in  32  byte address, wraps modulo 4*DEPTH
//   req_wdata     in  32  right-justified store data
//   rsp_valid     out 1   one-cycle response pulse
//   rsp_rdata     out 32  extended load data, 0 for stores and errors
//   rsp_err       out 1   misaligned access flag
// Build option:
//   DMEM_MISALIGN_CHK_EN  when defined, misaligned half/word accesses do not
//                         write and respond with rsp_err=1, rsp_rdata=0.
//                         When undefined, low address bits are forced to
//                         alignment and rsp_err stays 0.
// The RAM has no reset; its contents survive a reset.
// -----------------------------------------------------------------------------
module dmem_hs
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] LAST_CNT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_WAIT   = WAIT;
  localparam logic [1:0] S_RESP   = RESP;

  logic [1:0]  state_q, state_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  req_t        req_q, req_d;
  logic [31:0] rspRdata_q, rspRdata_d;
  logic        rspErr_q, rspErr_d;

  req_t        reqIn;
  req_t        acc;
  logic        commit;
  logic        memWe;
  logic [AW-1:0] wordIdx;
  logic [31:0] memWord;
  logic [31:0] merged;
  logic [31:0] loadData;
  logic [3:0]  be;
  logic        misaligned;
  logic        fault;
  logic        unusedBits;

  logic [31:0] mem [DEPTH];

  always_comb begin
    reqIn.we         = req_we;
    reqIn.size       = req_size;
    reqIn.isUnsigned = req_unsigned;
    reqIn.addr       = req_addr;
    reqIn.wdata      = req_wdata;
  end

  // With zero wait states the access commits on the acceptance edge itself,
  // before the request register holds it, so take the live inputs then.
  assign acc     = (state_q == S_IDLE) ? reqIn : req_q;
  assign wordIdx = acc.addr[AW+1:2];
  assign memWord = mem[wordIdx];

  dmem_lane_fmt u_lane_fmt (
    .size_i       (acc.size),
    .unsigned_i   (acc.isUnsigned),
    .offset_i     (acc.addr[1:0]),
    .wdata_i      (acc.wdata),
    .word_i       (memWord),
    .be_o         (be),
    .merged_o     (merged),
    .rdata_o      (loadData),
    .misaligned_o (misaligned)
  );

`ifdef DMEM_MISALIGN_CHK_EN
  assign fault      = misaligned;
  assign unusedBits = ^{be, acc.addr[31:AW+2]};
`else
  assign fault      = 1'b0;
  assign unusedBits = ^{be, acc.addr[31:AW+2], misaligned};
`endif

  // Sequencer: IDLE accepts, WAIT burns the wait states, RESP pulses once.
  // commit marks the edge that enters RESP, where the access happens.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    req_d     = req_q;
    commit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d     = reqIn;
          waitCnt_d = 4'd0;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        waitCnt_d = waitCnt_q + 4'd1;
        if (waitCnt_q == LAST_CNT) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Response data is registered at the commit edge and held afterwards.
  always_comb begin
    rspRdata_d = rspRdata_q;
    rspErr_d   = rspErr_q;
    if (commit) begin
      rspErr_d   = fault;
      rspRdata_d = (acc.we || fault) ? 32'h0 : loadData;
    end
  end

  // Reset on the commit edge must also suppress the write.
  assign memWe = commit && acc.we && !fault && !reset;

  // RAM write port; deliberately not reset.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[wordIdx] <= merged;
    end
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      waitCnt_q  <= 4'd0;
      req_q      <= '0;
      rspRdata_q <= 32'h0;
      rspErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      req_q      <= req_d;
      rspRdata_q <= rspRdata_d;
      rspErr_q   <= rspErr_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;

endmodule
